// File: rtl/pc_gen.sv
// Fetch PC generator: produces the icache request address, slot mask and misalign flag.
// Latency: all outputs registered; a redirect presented this cycle appears on pc_o after the next edge.
// Backpressure: pause_i[0] or inst_ready_i=0 holds pc_o; branches seen while held wait in a one-entry pending slot.
module pc_gen #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    FETCH_WIDTH  = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h1c000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [5:0]             pause_i,
   input  logic                   flush_i,
   input  logic [ADDR_WIDTH-1:0]  flush_target_i,
   input  logic                   is_branch_i,
   input  logic [ADDR_WIDTH-1:0]  branch_target_i,
   input  logic                   inst_ready_i,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   output logic                   inst_en_o,
   output logic [FETCH_WIDTH-1:0] inst_mask_o,
   output logic                   adef_o
);

   // Fetch block geometry: BLK_BYTES per request, OFF_W byte-offset bits inside a block.
   localparam int                    BLK_BYTES = 4 * FETCH_WIDTH;
   localparam int                    OFF_W     = $clog2(BLK_BYTES);
   localparam logic [ADDR_WIDTH-1:0] BLK_INC   = ADDR_WIDTH'(BLK_BYTES);
   localparam logic [ADDR_WIDTH-1:0] BLK_ALIGN = ~ADDR_WIDTH'(BLK_BYTES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic                    r_en;
   logic [FETCH_WIDTH-1:0]  r_mask;
   logic                    r_adef;
   logic                    r_pend_vld;
   logic [ADDR_WIDTH-1:0]   r_pend_tgt;

   logic                    w_run;
   logic                    w_adv;
   logic [ADDR_WIDTH-1:0]   w_seq_pc;
   logic [ADDR_WIDTH-1:0]   w_pc_nxt;
   logic                    w_pend_vld_nxt;
   logic [ADDR_WIDTH-1:0]   w_pend_tgt_nxt;
   logic                    w_en_nxt;
   logic                    w_adef_nxt;
   logic [FETCH_WIDTH-1:0]  w_mask_nxt;
   logic                    w_unused_pause;

   // Only the PC-stage stall bit matters here; the other stage bits are deliberately dropped.
   assign w_unused_pause = ^pause_i[5:1];

   assign w_run    = (r_state == S_RUN);
   // Advance when running, not stalled, and either the icache took the request or none is outstanding.
   assign w_adv    = w_run & ~pause_i[0] & (inst_ready_i | ~r_en);
   assign w_seq_pc = (r_pc & BLK_ALIGN) + BLK_INC;

   // Next-PC selection: flush > misalign hold > advance (new branch > pending > sequential) > hold/capture.
   always_comb begin
      w_pc_nxt       = r_pc;
      w_pend_vld_nxt = r_pend_vld;
      w_pend_tgt_nxt = r_pend_tgt;
      if (!w_run) begin
         if (flush_i) begin
            w_pc_nxt = flush_target_i;
         end
         w_pend_vld_nxt = 1'b0;
      end else if (flush_i) begin
         w_pc_nxt       = flush_target_i;
         w_pend_vld_nxt = 1'b0;
      end else if (r_adef) begin
         // Misaligned PC is parked until a flush; branches and advance are ignored.
         w_pc_nxt = r_pc;
      end else if (w_adv) begin
         if (is_branch_i) begin
            w_pc_nxt = branch_target_i;
         end else if (r_pend_vld) begin
            w_pc_nxt = r_pend_tgt;
         end else begin
            w_pc_nxt = w_seq_pc;
         end
         w_pend_vld_nxt = 1'b0;
      end else if (is_branch_i) begin
         // Stalled: remember the newest branch so it is not lost.
         w_pend_vld_nxt = 1'b1;
         w_pend_tgt_nxt = branch_target_i;
      end
   end

   // After any non-reset edge the FSM is in RUN, so request/misalign depend only on the next PC.
   assign w_en_nxt   = (w_pc_nxt[1:0] == 2'b00);
   assign w_adef_nxt = ~w_en_nxt;

   generate
      if (FETCH_WIDTH == 1) begin : g_mask_single
         assign w_mask_nxt = w_en_nxt;
      end else begin : g_mask_multi
         localparam int SLOT_W = OFF_W - 2;
         logic [SLOT_W-1:0] w_slot_nxt;
         assign w_slot_nxt = w_pc_nxt[OFF_W-1:2];
         for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
            // Slots below the entry offset belong to instructions before the target.
            assign w_mask_nxt[k] = w_en_nxt & (SLOT_W'(k) >= w_slot_nxt);
         end
      end
   endgenerate

   // State, PC, pending branch and registered outputs; reset discards everything in one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_VECTOR;
         r_en       <= 1'b0;
         r_mask     <= '0;
         r_adef     <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend_tgt <= '0;
      end else begin
         r_state    <= S_RUN;
         r_pc       <= w_pc_nxt;
         r_en       <= w_en_nxt;
         r_mask     <= w_mask_nxt;
         r_adef     <= w_adef_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_pend_tgt <= w_pend_tgt_nxt;
      end
   end

   assign pc_o        = r_pc;
   assign inst_en_o   = r_en;
   assign inst_mask_o = r_mask;
   assign adef_o      = r_adef;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_WIDTH, 32, fetch address width.
REQ-002 Parameter FETCH_WIDTH, 2, instructions per fetch block; power of two, 1..8.
REQ-003 Parameter RESET_VECTOR, 32'h1c000000, first fetch address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pause_i  input  6  stage stall vector; only bit 0 (PC stage) is used.
REQ-007 flush_i  input  1  exception/ertn redirect request.
REQ-008 flush_target_i  input  ADDR_WIDTH  flush redirect address.
REQ-009 is_branch_i  input  1  branch redirect request.
REQ-010 branch_target_i  input  ADDR_WIDTH  branch redirect address.
REQ-011 inst_ready_i  input  1  icache accepts the current request this cycle.
REQ-012 pc_o  output  ADDR_WIDTH  current fetch address (registered).
REQ-013 inst_en_o  output  1  fetch request valid (registered).
REQ-014 inst_mask_o  output  FETCH_WIDTH  valid-slot mask of current block (registered).
REQ-015 adef_o  output  1  pc_o misaligned; fetch suppressed (registered).

Function
REQ-016 The FSM SHALL have two states, IDLE and RUN; IDLE moves to RUN on the first clock edge with rst low, and RUN is left only by reset.
REQ-017 Definitions: BLK = 4*FETCH_WIDTH bytes; adv = RUN & ~pause_i[0] & (inst_ready_i | ~inst_en_o).
REQ-018 Flush SHALL take priority over everything: in RUN, flush_i=1 loads pc_o <= flush_target_i on the next edge regardless of pause_i[0] and inst_ready_i, abandons the outstanding request, and clears any pending branch.
REQ-019 A flush in IDLE SHALL load pc_o <= flush_target_i and still move to RUN.
REQ-020 A branch with adv=1 and no flush SHALL load pc_o <= branch_target_i on the next edge.
REQ-021 A branch with adv=0 and no flush SHALL be captured in a one-entry pending register that holds the target.
REQ-022 A later branch SHALL overwrite an existing pending entry.
REQ-023 On the first cycle with adv=1, the pending target SHALL load pc_o and the pending entry SHALL clear; a simultaneous new branch in that cycle SHALL take priority over the pending target.
REQ-024 Sequential advance (adv=1, no redirect) SHALL be pc_o <= (pc_o & ~(BLK-1)) + BLK, modulo 2^ADDR_WIDTH (wraps to 0).
REQ-025 When adv=0 and no flush occurs, pc_o SHALL hold.
REQ-026 inst_mask_o bit k SHALL be 1 iff k >= pc_o[log2(BLK)-1:2] and inst_en_o=1; otherwise 0.
REQ-027 For FETCH_WIDTH=1, inst_mask_o SHALL equal inst_en_o.
REQ-028 adef_o SHALL be 1 iff state is RUN and pc_o[1:0] != 0.
REQ-029 While adef_o=1: inst_en_o=0, sequential advance and branches are ignored, and only a flush changes pc_o.
REQ-030 In RUN, inst_en_o SHALL be 1 whenever adef_o=0, including during pause; a request held with inst_ready_i=0 keeps pc_o stable.
REQ-031 A simultaneous flush and branch SHALL resolve to the flush target, and the branch SHALL be discarded (not made pending).

Reset
REQ-032 While rst=1 on an edge: state=IDLE, pc_o=RESET_VECTOR, inst_en_o=0, inst_mask_o=0, adef_o=0, pending cleared; all other inputs are ignored.
REQ-033 Reset asserted mid-operation (pending branch, stall, or adef) SHALL discard all state within that one edge.
REQ-034 The first request after reset SHALL be issued one cycle after rst deasserts, at RESET_VECTOR.

Verification (FETCH_WIDTH=2, ADDR_WIDTH=32, inst_ready_i=1 unless noted)
REQ-035 Reset release: rst=1 for 2 cycles, then 0 -> cycle 1 after release: en=1, pc=1c000000, mask=2'b11; then pc=1c000008, then 1c000010.
REQ-036 Branch to 1c000104 -> next pc=1c000104, mask=2'b10; following cycle pc=1c000108, mask=2'b11.
REQ-037 Branch to 1c000200 while pause_i[0]=1 for 3 cycles -> pc holds, en=1; pc=1c000200 on the first edge after pause drops.
REQ-038 Pending branch plus flush to 1c008000 with pause_i[0]=1 and inst_ready_i=0 -> pc=1c008000 next edge; the pending branch is never taken.
REQ-039 Same-cycle flush to 1c00c000 and branch to 1c000300 -> pc=1c00c000.
REQ-040 Branch to 1c000102 -> adef_o=1, en=0, mask=0, pc holds; flush to 1c00c000 -> adef_o=0, en=1. Separately, sequential advance from pc=fffffff8 -> pc=00000000.
